// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store types: memory funct3 encoding, LSU state, byte-enable patterns.
// MISALIGN_TRAP_EN (when defined) makes lsu trap misaligned halves/words instead of accessing memory.
package riscv_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_mem_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StResp
  } lsu_state_t;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } mem_size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Unlisted funct3 codes (011, 110, 111) fall through to word accesses.
  function automatic mem_size_e mem_size(input logic [2:0] funct3);
    mem_size_e sz;
    case (funct3)
      F3_LB, F3_LBU: sz = SzByte;
      F3_LH, F3_LHU: sz = SzHalf;
      default:       sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    mem_size_e sz;
    sz = mem_size(funct3);
    return ((sz == SzHalf) && addr_lo[0]) || ((sz == SzWord) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores (byte enables, replicated data) and lane select/extension for loads.
// Half and word accesses ignore the low address bits they cannot use.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  mem_size_e   size;
  logic [31:0] shifted;

  always_comb begin
    size    = mem_size(funct3_i);
    be_o    = BE_WORD;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    shifted = '0;
    unique case (size)
      SzByte: begin
        be_o    = BE_BYTE << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        // funct3[2] set selects the zero-extending variants.
        rdata_o = {{24{shifted[7] & ~funct3_i[2]}}, shifted[7:0]};
      end
      SzHalf: begin
        be_o    = BE_HALF << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        shifted = rdata_i >> {addr_lo_i[1], 4'b0000};
        rdata_o = {{16{shifted[15] & ~funct3_i[2]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: latches one MEM-stage request, runs a req/gnt/rvalid memory handshake, returns
// a one-cycle response. Define MISALIGN_TRAP_EN to fault misaligned accesses without touching memory.
module lsu
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_fault,
  output logic              stall
);

  lsu_state_t        state_q, state_d;
  logic              is_store_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rdata_q;
  logic              accept;
  logic              misalign;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [31:0]       ld_data;

  assign accept = req_valid && req_ready;

  lsu_align u_align (
    .funct3_i  (funct3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (mem_rdata),
    .be_o      (be),
    .wdata_o   (wdata_lane),
    .rdata_o   (ld_data)
  );

`ifdef MISALIGN_TRAP_EN
  logic fault_q;

  assign misalign  = misaligned(req_funct3, req_addr[1:0]);
  assign rsp_fault = rsp_valid & fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= misalign;
    end
  end
`else
  assign misalign  = 1'b0;
  assign rsp_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = misalign ? StResp : StReq;
      StReq:  if (mem_gnt) state_d = is_store_q ? StResp : StWait;
      StWait: if (mem_rvalid) state_d = StResp;
      StResp: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= req_is_store;
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        rd_q       <= req_rd;
        rdata_q    <= '0;
      end else if ((state_q == StWait) && mem_rvalid) begin
        rdata_q <= ld_data;
      end
    end
  end

  // Memory-side outputs are forced to zero outside REQ so idle/reset values are clean.
  assign mem_req   = (state_q == StReq);
  assign mem_we    = mem_req & is_store_q;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = mem_req ? wdata_lane : '0;

  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_rd    = rsp_valid ? rd_q : '0;

  assign req_ready = !rst && (state_q == StIdle);
  assign stall     = !rst && (((state_q == StIdle) && req_valid) || (state_q == StReq) ||
                              (state_q == StWait));

endmodule
